uart_rx_capture: RTL and testbench
==================================

UART_RX_CAPTURE -- requirements
Module: uart_rx_capture

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 868, meaning XCLK cycles per UART bit; legal range 4..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning received-byte buffer entries; power of two, 2..64.
REQ-003 SHALL have port XCLK, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port XRES, input, 1, reset; asynchronous and active-high.
REQ-005 SHALL have port UART_RXD, input, 1, serial line driven by the SoC UART_TXD; idle high; asynchronous to XCLK.
REQ-006 SHALL have port RX_DATA, output, 8, byte at FIFO head.
REQ-007 SHALL have port RX_VALID, output, 1, high when the FIFO is non-empty.
REQ-008 SHALL have port RX_READY, input, 1, consumer accepts the head byte.
REQ-009 SHALL have port FRAME_ERR, output, 1, sticky framing-error flag.
REQ-010 SHALL have port OVERRUN, output, 1, sticky byte-dropped-on-full flag.
REQ-011 SHALL have port CLR_ERR, input, 1, one-cycle clear of FRAME_ERR and OVERRUN.
REQ-012 SHALL have port RX_COUNT, output, 16, count of bytes written into the FIFO.

Function
REQ-013 SHALL pass UART_RXD through a 2-flop synchronizer reset to 1; all decisions use the synchronized value.
REQ-014 SHALL implement states IDLE, START, DATA, STOP, BREAK; 8N1 frames, LSB first.
REQ-015 IDLE: on a synchronized 1->0 transition SHALL go to START and load the bit timer with BAUD_DIV/2 (integer division).
REQ-016 START: at timer expiry SHALL sample; 0 -> DATA with timer = BAUD_DIV and bit index 0; 1 -> false start, back to IDLE with no flag.
REQ-017 DATA: SHALL sample once per BAUD_DIV cycles into the shift register; after the 8th sample SHALL go to STOP with timer = BAUD_DIV.
REQ-018 STOP: at expiry, sample 1 SHALL push the byte and return to IDLE; sample 0 SHALL discard the byte, set FRAME_ERR and go to BREAK.
REQ-019 BREAK: SHALL stay until the synchronized line reads 1, then go to IDLE.
REQ-020 Push SHALL occur in the cycle after the stop-bit sample; RX_VALID SHALL rise in the cycle after the push.
REQ-021 Pop SHALL occur on any rising edge with RX_VALID and RX_READY both high; RX_DATA SHALL show the next entry in the following cycle.
REQ-022 A push with the FIFO full and no same-cycle pop SHALL drop the new byte, set OVERRUN and leave FIFO contents and RX_COUNT unchanged.
REQ-023 A push and pop in the same cycle when full SHALL both succeed; when empty, the push SHALL succeed and the pop SHALL not occur.
REQ-024 RX_COUNT SHALL increment by 1 per accepted push and wrap 0xFFFF -> 0x0000.
REQ-025 CLR_ERR SHALL clear both sticky flags; an error event in the same cycle SHALL win, leaving that flag set.
REQ-026 RX_DATA SHALL hold its value while RX_VALID is low and RX_READY is ignored.

Reset
REQ-027 XRES high SHALL immediately force state IDLE, FIFO empty, RX_VALID=0, RX_DATA=0x00, FRAME_ERR=0, OVERRUN=0, RX_COUNT=0, synchronizer=1.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no push and no flag; after release, reception SHALL restart only on a new falling edge.

Verification (BAUD_DIV=4, FIFO_DEPTH=4)
REQ-029 Send 0xA5 with a valid stop bit -> RX_DATA=0xA5, RX_VALID=1, RX_COUNT=1, no flags.
REQ-030 Pulse UART_RXD low for 1 cycle -> no push, state returns to IDLE, no flags.
REQ-031 Send 0x3C with stop bit 0, then hold line high -> no push, FRAME_ERR=1, next good byte 0x11 received normally.
REQ-032 Send 0x01..0x05 with RX_READY=0 -> FIFO holds 0x01..0x04, OVERRUN=1, RX_COUNT=4; drain in order.
REQ-033 Assert XRES during bit 3 of 0x7E -> outputs at reset values, no push; next frame 0x42 received correctly.
REQ-034 Pulse CLR_ERR in the same cycle as a new framing error -> FRAME_ERR remains 1, OVERRUN cleared.

Source files
------------

// File: rtl/uart_rx_capture.sv
// uart_rx_capture
//   Receives 8N1 serial frames (LSB first) from an SoC UART transmitter,
//   buffers the received bytes in a small FIFO and reports framing errors
//   and dropped bytes through sticky flags.
//
// Parameters
//   BAUD_DIV   : XCLK cycles per UART bit (4..65535)
//   FIFO_DEPTH : receive buffer entries (power of two, 2..64)
//
// Ports
//   XCLK      in   system clock, all state changes on its rising edge
//   XRES      in   asynchronous active-high reset
//   UART_RXD  in   serial line, idle high, asynchronous to XCLK
//   RX_DATA   out  [7:0]  byte at the FIFO head
//   RX_VALID  out  FIFO non-empty
//   RX_READY  in   consumer accepts the head byte
//   FRAME_ERR out  sticky framing-error flag
//   OVERRUN   out  sticky byte-dropped-on-full flag
//   CLR_ERR   in   one-cycle clear of FRAME_ERR and OVERRUN
//   RX_COUNT  out  [15:0] number of bytes written into the FIFO (wraps)

module uart_rx_capture #(
  parameter int BAUD_DIV   = 868,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        XCLK,
  input  logic        XRES,
  input  logic        UART_RXD,
  output logic [7:0]  RX_DATA,
  output logic        RX_VALID,
  input  logic        RX_READY,
  output logic        FRAME_ERR,
  output logic        OVERRUN,
  input  logic        CLR_ERR,
  output logic [15:0] RX_COUNT
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [15:0] BIT_LOAD = 16'(BAUD_DIV);
  localparam logic [15:0] HALF_LOAD = 16'(BAUD_DIV / 2);
  localparam logic [AW:0] DEPTH_C  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0] CNT_ONE  = 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  // Synchronizer and edge detector
  logic rx_meta;
  logic rx_sync;
  logic rx_prev;

  // Receiver state
  state_t      state, state_next;
  logic [15:0] timer, timer_next;
  logic [2:0]  bit_idx, bit_idx_next;
  logic [7:0]  shift_reg, shift_next;
  logic        push_req, push_next;
  logic [7:0]  push_data;
  logic        frame_err_set;

  // FIFO
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [7:0]    last_data;
  logic          full;
  logic          do_pop;
  logic          do_push;
  logic          overrun_set;

  // The line is asynchronous; everything downstream sees only rx_sync.
  // rx_prev holds the previous synchronized value for falling-edge detection.
  // All three flops reset to the idle (high) level so reset release on an
  // idle line never looks like a start bit.
  always_ff @(posedge XCLK or posedge XRES) begin
    if (XRES) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= UART_RXD;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Receiver state register. push_req is a registered pulse so the FIFO
  // write happens in the cycle after the stop-bit sample.
  always_ff @(posedge XCLK or posedge XRES) begin
    if (XRES) begin
      state     <= IDLE;
      timer     <= 16'd0;
      bit_idx   <= 3'd0;
      shift_reg <= 8'd0;
      push_req  <= 1'b0;
      push_data <= 8'd0;
    end else begin
      state     <= state_next;
      timer     <= timer_next;
      bit_idx   <= bit_idx_next;
      shift_reg <= shift_next;
      push_req  <= push_next;
      if (push_next) begin
        push_data <= shift_reg;
      end
    end
  end

  // The bit timer is loaded with N and the line is sampled on the cycle
  // where it reads 1, i.e. N cycles after loading. START uses half a bit so
  // all later samples land near the middle of each bit.
  always_comb begin
    state_next    = state;
    timer_next    = timer;
    bit_idx_next  = bit_idx;
    shift_next    = shift_reg;
    push_next     = 1'b0;
    frame_err_set = 1'b0;

    case (state)
      IDLE: begin
        if (rx_prev && !rx_sync) begin
          state_next = START;
          timer_next = HALF_LOAD;
        end
      end

      START: begin
        if (timer == 16'd1) begin
          if (!rx_sync) begin
            state_next   = DATA;
            timer_next   = BIT_LOAD;
            bit_idx_next = 3'd0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          timer_next = timer - 16'd1;
        end
      end

      DATA: begin
        if (timer == 16'd1) begin
          shift_next = {rx_sync, shift_reg[7:1]};
          timer_next = BIT_LOAD;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end else begin
          timer_next = timer - 16'd1;
        end
      end

      STOP: begin
        if (timer == 16'd1) begin
          if (rx_sync) begin
            push_next  = 1'b1;
            state_next = IDLE;
          end else begin
            frame_err_set = 1'b1;
            state_next    = BREAK;
          end
        end else begin
          timer_next = timer - 16'd1;
        end
      end

      BREAK: begin
        if (rx_sync) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // A pop needs a non-empty FIFO, so an empty-FIFO push with RX_READY high
  // only writes. When full, a same-cycle pop frees the slot being written.
  assign full        = (count == DEPTH_C);
  assign RX_VALID    = (count != '0);
  assign do_pop      = RX_VALID && RX_READY;
  assign do_push     = push_req && (!full || do_pop);
  assign overrun_set = push_req && full && !do_pop;

  // While empty, RX_DATA keeps showing the last byte that was at the head.
  assign RX_DATA = RX_VALID ? mem[rd_ptr] : last_data;

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge XCLK or posedge XRES) begin
    if (XRES) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= 8'd0;
      end
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_data <= 8'd0;
    end else begin
      if (RX_VALID) begin
        last_data <= mem[rd_ptr];
      end
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Sticky flags: a new error event in the same cycle as CLR_ERR wins.
  always_ff @(posedge XCLK or posedge XRES) begin
    if (XRES) begin
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      if (frame_err_set) begin
        FRAME_ERR <= 1'b1;
      end else if (CLR_ERR) begin
        FRAME_ERR <= 1'b0;
      end
      if (overrun_set) begin
        OVERRUN <= 1'b1;
      end else if (CLR_ERR) begin
        OVERRUN <= 1'b0;
      end
    end
  end

  // Accepted-byte counter, wraps naturally at 16 bits.
  always_ff @(posedge XCLK or posedge XRES) begin
    if (XRES) begin
      RX_COUNT <= 16'd0;
    end else if (do_push) begin
      RX_COUNT <= RX_COUNT + 16'd1;
    end
  end

endmodule

// File: tb/tb_uart_rx_capture.sv
// tb_uart_rx_capture
//   Directed self-checking bench for uart_rx_capture with BAUD_DIV=4 and
//   FIFO_DEPTH=4. Frames are driven cycle by cycle so error clears, pops and
//   resets can be placed on exact clock edges relative to the start bit.

module tb_uart_rx_capture;

  localparam int BAUD  = 4;
  localparam int DEPTH = 4;
  // Edge (counted from the edge before the start bit) on which the stop bit
  // is sampled: 3 cycles of sync/edge detect, half a bit, then 9 full bits.
  localparam int SAMPLE_EDGE = 3 + BAUD / 2 + 9 * BAUD;
  localparam int PUSH_EDGE   = SAMPLE_EDGE + 1;
  localparam int FRAME_EDGES = 10 * BAUD + 4;
  localparam int NONE        = -1;

  logic        xclk;
  logic        xres;
  logic        uart_rxd;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        frame_err;
  logic        overrun;
  logic        clr_err;
  logic [15:0] rx_count;

  int checks;
  int errors;

  uart_rx_capture #(
    .BAUD_DIV  (BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .XCLK     (xclk),
    .XRES     (xres),
    .UART_RXD (uart_rxd),
    .RX_DATA  (rx_data),
    .RX_VALID (rx_valid),
    .RX_READY (rx_ready),
    .FRAME_ERR(frame_err),
    .OVERRUN  (overrun),
    .CLR_ERR  (clr_err),
    .RX_COUNT (rx_count)
  );

  initial xclk = 1'b0;
  always #5 xclk = ~xclk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives one frame starting right after a clock edge. clrEdge/popEdge pulse
  // CLR_ERR/RX_READY so they are high exactly at that edge; rstEdge raises
  // XRES just after that edge and leaves it asserted.
  task automatic applyStimulus(input logic [7:0] b, input logic stopBit,
                               input int clrEdge, input int popEdge,
                               input int rstEdge);
    logic [9:0] frame;
    frame = {stopBit, b, 1'b0};
    for (int i = 0; i < FRAME_EDGES; i++) begin
      if (i < 10 * BAUD) uart_rxd = frame[i / BAUD];
      else uart_rxd = 1'b1;
      clr_err  = (i + 1 == clrEdge);
      rx_ready = (i + 1 == popEdge);
      if (i == rstEdge) xres = 1'b1;
      @(posedge xclk);
      #1;
    end
    clr_err  = 1'b0;
    rx_ready = 1'b0;
  endtask

  task automatic popByte(input string tag, input logic [7:0] expected);
    checkOutput({tag, "_valid"}, 16'(rx_valid), 16'h0001);
    checkOutput({tag, "_data"}, 16'(rx_data), 16'(expected));
    rx_ready = 1'b1;
    @(posedge xclk);
    #1;
    rx_ready = 1'b0;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    xres     = 1'b1;
    uart_rxd = 1'b1;
    rx_ready = 1'b0;
    clr_err  = 1'b0;
    repeat (3) @(posedge xclk);
    #1;

    // Reset values
    checkOutput("rst_valid", 16'(rx_valid), 16'h0000);
    checkOutput("rst_data", 16'(rx_data), 16'h0000);
    checkOutput("rst_ferr", 16'(frame_err), 16'h0000);
    checkOutput("rst_ovr", 16'(overrun), 16'h0000);
    checkOutput("rst_count", rx_count, 16'h0000);
    xres = 1'b0;
    @(posedge xclk);
    #1;

    // Good byte 0xA5
    applyStimulus(8'hA5, 1'b1, NONE, NONE, NONE);
    checkOutput("a5_data", 16'(rx_data), 16'h00A5);
    checkOutput("a5_valid", 16'(rx_valid), 16'h0001);
    checkOutput("a5_count", rx_count, 16'h0001);
    checkOutput("a5_ferr", 16'(frame_err), 16'h0000);
    checkOutput("a5_ovr", 16'(overrun), 16'h0000);
    popByte("a5_pop", 8'hA5);
    checkOutput("a5_empty", 16'(rx_valid), 16'h0000);
    // RX_READY while empty is ignored and RX_DATA holds
    rx_ready = 1'b1;
    repeat (2) @(posedge xclk);
    #1;
    rx_ready = 1'b0;
    checkOutput("empty_hold_data", 16'(rx_data), 16'h00A5);
    checkOutput("empty_hold_count", rx_count, 16'h0001);

    // One-cycle glitch: false start
    uart_rxd = 1'b0;
    @(posedge xclk);
    #1;
    uart_rxd = 1'b1;
    repeat (3 * BAUD) @(posedge xclk);
    #1;
    checkOutput("glitch_valid", 16'(rx_valid), 16'h0000);
    checkOutput("glitch_count", rx_count, 16'h0001);
    checkOutput("glitch_ferr", 16'(frame_err), 16'h0000);

    // Framing error on 0x3C, then a good 0x11
    applyStimulus(8'h3C, 1'b0, NONE, NONE, NONE);
    checkOutput("ferr_flag", 16'(frame_err), 16'h0001);
    checkOutput("ferr_valid", 16'(rx_valid), 16'h0000);
    checkOutput("ferr_count", rx_count, 16'h0001);
    applyStimulus(8'h11, 1'b1, NONE, NONE, NONE);
    checkOutput("b11_count", rx_count, 16'h0002);
    popByte("b11_pop", 8'h11);
    checkOutput("b11_empty", 16'(rx_valid), 16'h0000);

    // Plain CLR_ERR clears the framing flag
    clr_err = 1'b1;
    @(posedge xclk);
    #1;
    clr_err = 1'b0;
    checkOutput("clr_ferr", 16'(frame_err), 16'h0000);

    // Overrun: five bytes into a four-entry FIFO with no reads
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(8'(k), 1'b1, NONE, NONE, NONE);
    end
    checkOutput("ovr_flag", 16'(overrun), 16'h0001);
    checkOutput("ovr_count", rx_count, 16'h0006);
    checkOutput("ovr_head", 16'(rx_data), 16'h0001);

    // Push and pop in the same cycle while full: both succeed
    applyStimulus(8'h06, 1'b1, NONE, PUSH_EDGE, NONE);
    checkOutput("pp_count", rx_count, 16'h0007);
    checkOutput("pp_ovr", 16'(overrun), 16'h0001);
    popByte("drain0", 8'h02);
    popByte("drain1", 8'h03);
    popByte("drain2", 8'h04);
    popByte("drain3", 8'h06);
    checkOutput("drain_empty", 16'(rx_valid), 16'h0000);

    // CLR_ERR coinciding with a new framing error
    applyStimulus(8'h3C, 1'b0, SAMPLE_EDGE, NONE, NONE);
    checkOutput("clrwin_ferr", 16'(frame_err), 16'h0001);
    checkOutput("clrwin_ovr", 16'(overrun), 16'h0000);
    checkOutput("clrwin_count", rx_count, 16'h0007);

    // Reset during bit 3 of 0x7E, held until the line is idle again
    applyStimulus(8'h7E, 1'b1, NONE, NONE, 5 * BAUD - 2);
    checkOutput("mid_rst_valid", 16'(rx_valid), 16'h0000);
    checkOutput("mid_rst_data", 16'(rx_data), 16'h0000);
    checkOutput("mid_rst_ferr", 16'(frame_err), 16'h0000);
    checkOutput("mid_rst_count", rx_count, 16'h0000);
    xres = 1'b0;
    repeat (3 * BAUD) @(posedge xclk);
    #1;
    checkOutput("post_rst_valid", 16'(rx_valid), 16'h0000);
    checkOutput("post_rst_count", rx_count, 16'h0000);
    applyStimulus(8'h42, 1'b1, NONE, NONE, NONE);
    checkOutput("b42_count", rx_count, 16'h0001);
    checkOutput("b42_ferr", 16'(frame_err), 16'h0000);
    popByte("b42_pop", 8'h42);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
